// File: rtl/extra_slot_scheduler.sv
// Request/grant arbiter for the shared third bus cycle of each 4-cycle memory frame.
// Urgent requesters are forced in after MAX_WAIT lost decisions; otherwise round-robin.
module extra_slot_scheduler #(
  parameter int              NREQ     = 4,
  parameter logic [NREQ-1:0] URGENT   = 4'b0100,
  parameter int              MAX_WAIT = 3,
  parameter int              WCW      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk8_en_p_i,
  input  logic [1:0]           busCycle_i,
  input  logic                 memoryLatch_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*22-1:0]   reqAddr_i,
  output logic [NREQ-1:0]      grant_o,
  output logic [NREQ-1:0]      done_o,
  output logic [21:0]          slotAddr_o,
  output logic                 slotActive_o,
  output logic [15:0]          idleSlots_o
);

  localparam int AW = 22;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [AW-1:0]   slotAddr_q, slotAddr_d;
  logic [15:0]     idleSlots_q, idleSlots_d;
  logic [PW-1:0]   rrPtr_q, rrPtr_d;
  logic [WCW-1:0]  waitCnt_q [NREQ];
  logic [WCW-1:0]  waitCnt_d [NREQ];
  logic            doneSent_q, doneSent_d;

  logic            decision;
  logic            slotEnd;
  logic            anyReq;
  logic            forcedHit;
  logic [PW-1:0]   forcedIdx;
  logic [PW-1:0]   rrIdx;
  logic [PW-1:0]   winIdx;

  assign decision = clk8_en_p_i && (busCycle_i == 2'b01);
  assign slotEnd  = memoryLatch_i && (busCycle_i == 2'b10) && !doneSent_q;
  assign anyReq   = |req_i;

  // Descending loops so the last hit written is the lowest index / nearest to rrPtr.
  always_comb begin
    logic [PW-1:0] cand;
    forcedHit = 1'b0;
    forcedIdx = '0;
    rrIdx     = '0;
    cand      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (URGENT[i] && req_i[i] && (waitCnt_q[i] >= WCW'(MAX_WAIT))) begin
        forcedHit = 1'b1;
        forcedIdx = PW'(i);
      end
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(rrPtr_q) + k) % NREQ);
      if (req_i[cand]) begin
        rrIdx = cand;
      end
    end
  end

  assign winIdx = forcedHit ? forcedIdx : rrIdx;

  always_comb begin
    grant_d     = grant_q;
    slotAddr_d  = slotAddr_q;
    idleSlots_d = idleSlots_q;
    rrPtr_d     = rrPtr_q;
    waitCnt_d   = waitCnt_q;
    done_d      = slotEnd ? grant_q : '0;
    doneSent_d  = doneSent_q | slotEnd;
    if (decision) begin
      doneSent_d = 1'b0;
      if (anyReq) begin
        grant_d    = {{(NREQ-1){1'b0}}, 1'b1} << winIdx;
        slotAddr_d = reqAddr_i[int'(winIdx)*AW +: AW];
        for (int i = 0; i < NREQ; i++) begin
          if (PW'(i) == winIdx) begin
            waitCnt_d[i] = '0;
          end else if (req_i[i] && (waitCnt_q[i] != '1)) begin
            waitCnt_d[i] = waitCnt_q[i] + 1'b1;
          end
        end
        if (!forcedHit) begin
          rrPtr_d = (winIdx == PW'(NREQ - 1)) ? '0 : winIdx + 1'b1;
        end
      end else begin
        grant_d    = '0;
        slotAddr_d = '0;
        if (idleSlots_q != 16'hFFFF) begin
          idleSlots_d = idleSlots_q + 16'd1;
        end
      end
    end else if (clk8_en_p_i) begin
      // Any other clk8 edge ends the extra cycle, including out-of-order busCycle jumps.
      grant_d    = '0;
      slotAddr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= '0;
      done_q      <= '0;
      slotAddr_q  <= '0;
      idleSlots_q <= '0;
      rrPtr_q     <= '0;
      doneSent_q  <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        waitCnt_q[i] <= '0;
      end
    end else begin
      grant_q     <= grant_d;
      done_q      <= done_d;
      slotAddr_q  <= slotAddr_d;
      idleSlots_q <= idleSlots_d;
      rrPtr_q     <= rrPtr_d;
      doneSent_q  <= doneSent_d;
      for (int i = 0; i < NREQ; i++) begin
        waitCnt_q[i] <= waitCnt_d[i];
      end
    end
  end

  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign slotAddr_o   = slotAddr_q;
  assign slotActive_o = |grant_q;
  assign idleSlots_o  = idleSlots_q;

endmodule
